// File: rtl/csr_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// csr_rmw_ctrl
// Initiator side of the CSR register-file access interface. Takes one CSR
// instruction (CSRRW/RS/RC and the immediate forms) and performs it as a
// sequenced read-modify-write: read the old value, issue one write pulse
// if needed, then return the old value for the rd writeback.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_*_i / req_ready_o
//                       instruction request from execute; accepted in IDLE
//   flush_i             abort the in-flight operation (trap)
//   csr_raddr_o / csr_rdata_i
//                       CSR file read port (read data is combinational)
//   csr_we_o / csr_waddr_o / csr_wdata_o
//                       CSR file write port, one-cycle write pulse
//   rsp_*_o             completion pulse with rd writeback information
//   illegal_o / illegal_pc_o
//                       illegal-instruction report, coincident with rsp
//   busy_o              high while an operation is in flight
// ---------------------------------------------------------------------------
module csr_rmw_ctrl #(
    parameter int DATA_W      = 32,
    parameter bit RO_CHECK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [11:0]       req_addr_i,
    input  logic [4:0]        req_rs1_idx_i,
    input  logic [DATA_W-1:0] req_rs1_data_i,
    input  logic [4:0]        req_rd_i,
    input  logic [31:0]       req_pc_i,

    input  logic              flush_i,

    output logic [11:0]       csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic              csr_we_o,
    output logic [11:0]       csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,

    output logic              rsp_valid_o,
    output logic              rsp_we_o,
    output logic [4:0]        rsp_rd_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              illegal_o,
    output logic [31:0]       illegal_pc_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [2:0]          funct3_q,  funct3_d;
    logic [11:0]         addr_q,    addr_d;
    logic [4:0]          rs1_idx_q, rs1_idx_d;
    logic [4:0]          rd_q,      rd_d;
    logic [31:0]         pc_q,      pc_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [DATA_W-1:0]   old_q,     old_d;
    logic                illegal_q, illegal_d;

    // Decode of the latched instruction, used in the RD cycle.
    logic                write_intent;
    logic                illegal_rd;
    logic [DATA_W-1:0]   new_value;

    // RW forms always write; set/clear forms write only when rs1/zimm
    // field is non-zero (reads without side effects).
    assign write_intent = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    assign illegal_rd   = (funct3_q[1:0] == 2'b00) ||
                          (RO_CHECK_EN && write_intent && (addr_q[11:10] == 2'b11));

    always_comb begin
        unique case (funct3_q[1:0])
            2'b01:   new_value = operand_q;
            2'b10:   new_value = old_q | operand_q;
            default: new_value = old_q & ~operand_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_idx_q <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            operand_q <= '0;
            old_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1_idx_q <= rs1_idx_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            operand_q <= operand_d;
            old_q     <= old_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        rs1_idx_d    = rs1_idx_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        operand_d    = operand_q;
        old_d        = old_q;
        illegal_d    = illegal_q;

        req_ready_o  = 1'b0;
        csr_raddr_o  = '0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        rsp_valid_o  = 1'b0;
        rsp_we_o     = 1'b0;
        rsp_rd_o     = '0;
        rsp_data_o   = '0;
        illegal_o    = 1'b0;
        illegal_pc_o = '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                // A flush in the same cycle blocks acceptance.
                if (req_valid_i && !flush_i) begin
                    funct3_d  = req_funct3_i;
                    addr_d    = req_addr_i;
                    rs1_idx_d = req_rs1_idx_i;
                    rd_d      = req_rd_i;
                    pc_d      = req_pc_i;
                    operand_d = req_funct3_i[2]
                              ? {{(DATA_W-5){1'b0}}, req_rs1_idx_i}
                              : req_rs1_data_i;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                csr_raddr_o = addr_q;
                old_d       = csr_rdata_i;
                illegal_d   = illegal_rd;
                state_d     = (write_intent && !illegal_rd) ? S_WR : S_RSP;
            end
            S_WR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = addr_q;
                csr_wdata_o = new_value;
                state_d     = S_RSP;
            end
            S_RSP: begin
                rsp_valid_o  = 1'b1;
                rsp_we_o     = (rd_q != 5'd0) && !illegal_q;
                rsp_rd_o     = rd_q;
                rsp_data_o   = old_q;
                illegal_o    = illegal_q;
                illegal_pc_o = illegal_q ? pc_q : 32'd0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Trap flush: abandon the operation without any side effect in
        // this cycle.
        if (flush_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            csr_we_o    = 1'b0;
            rsp_valid_o = 1'b0;
            illegal_o   = 1'b0;
        end

        // A reset cycle must never commit a CSR write.
        if (rst) begin
            csr_we_o = 1'b0;
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_rmw_ctrl
// Self-checking bench for csr_rmw_ctrl. A behavioural CSR file answers the
// DUT's reads; a reference copy of the CSR contents predicts every write
// and response, which are queued by the driver and popped by a monitor.
// ---------------------------------------------------------------------------
module tb_csr_rmw_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [2:0]    req_funct3_i = '0;
    logic [11:0]   req_addr_i = '0;
    logic [4:0]    req_rs1_idx_i = '0;
    logic [DW-1:0] req_rs1_data_i = '0;
    logic [4:0]    req_rd_i = '0;
    logic [31:0]   req_pc_i = '0;
    logic          flush_i = 1'b0;
    logic [11:0]   csr_raddr_o;
    logic [DW-1:0] csr_rdata_i;
    logic          csr_we_o;
    logic [11:0]   csr_waddr_o;
    logic [DW-1:0] csr_wdata_o;
    logic          rsp_valid_o;
    logic          rsp_we_o;
    logic [4:0]    rsp_rd_o;
    logic [DW-1:0] rsp_data_o;
    logic          illegal_o;
    logic [31:0]   illegal_pc_o;
    logic          busy_o;

    always #5 clk = ~clk;

    csr_rmw_ctrl #(.DATA_W(DW), .RO_CHECK_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_rs1_idx_i  (req_rs1_idx_i),
        .req_rs1_data_i (req_rs1_data_i),
        .req_rd_i       (req_rd_i),
        .req_pc_i       (req_pc_i),
        .flush_i        (flush_i),
        .csr_raddr_o    (csr_raddr_o),
        .csr_rdata_i    (csr_rdata_i),
        .csr_we_o       (csr_we_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_we_o       (rsp_we_o),
        .rsp_rd_o       (rsp_rd_o),
        .rsp_data_o     (rsp_data_o),
        .illegal_o      (illegal_o),
        .illegal_pc_o   (illegal_pc_o),
        .busy_o         (busy_o)
    );

    // ---------------- CSR file model ----------------
    logic [31:0] csr_mem [4096];
    logic [31:0] ref_mem [4096];
    logic        fill = 1'b1;
    logic        tb_set = 1'b0;
    logic [11:0] tb_set_addr = '0;
    logic [31:0] tb_set_val = '0;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return {a, ~a, 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= init_val(12'(i));
        end else if (csr_we_o) begin
            csr_mem[csr_waddr_o] <= csr_wdata_o;
        end else if (tb_set) begin
            csr_mem[tb_set_addr] <= tb_set_val;
        end
    end

    assign csr_rdata_i = csr_mem[csr_raddr_o];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          off;
    } wr_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        logic [31:0] ipc;
        int          off;
    } rsp_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;
    int accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        wr_t  we;
        rsp_t re;
        if (!rst && !fill) begin
            check("busy_vs_ready", busy_o, !req_ready_o);
            if (illegal_o && !rsp_valid_o) fail_now("illegal_without_rsp");
            if (csr_we_o) begin
                if (wr_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", csr_waddr_o, we.addr);
                    check("wr_data", csr_wdata_o, we.data);
                    check("wr_latency", cyc, accept_cyc + we.off);
                end
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_we", rsp_we_o, re.we);
                    check("rsp_rd", rsp_rd_o, re.rd);
                    check("rsp_data", rsp_data_o, re.data);
                    check("rsp_illegal", illegal_o, re.ill);
                    check("rsp_illegal_pc", illegal_pc_o, re.ipc);
                    check("rsp_latency", cyc, accept_cyc + re.off);
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
        ref_mem[a]  = v;
        tb_set      = 1'b1;
        tb_set_addr = a;
        tb_set_val  = v;
        @(posedge clk); #1;
        tb_set      = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready_o) fail_now("ready_timeout");
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [4:0] idx, input logic [31:0] data,
                             input logic [4:0] rd, input logic [31:0] pc);
        req_valid_i    = 1'b1;
        req_funct3_i   = f3;
        req_addr_i     = addr;
        req_rs1_idx_i  = idx;
        req_rs1_data_i = data;
        req_rd_i       = rd;
        req_pc_i       = pc;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [4:0] idx, input logic [31:0] data,
                         input logic [4:0] rd, input logic [31:0] pc);
        logic [31:0] op, old, nv;
        logic        intent, ill, writes;
        wr_t         w;
        rsp_t        r;
        int          n, target;

        // Architectural behaviour of the CSR instruction.
        op     = f3[2] ? {27'd0, idx} : data;
        intent = (f3[1:0] == 2'b01) || (idx != 5'd0);
        ill    = (f3[1:0] == 2'b00) || (intent && addr[11:10] == 2'b11);
        writes = intent && !ill;
        old    = ref_mem[addr];
        case (f3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            default: nv = old & ~op;
        endcase

        if (writes) begin
            w.addr = addr;
            w.data = nv;
            w.off  = 1;
            wr_q.push_back(w);
            ref_mem[addr] = nv;
        end
        r.we   = (rd != 5'd0) && !ill;
        r.rd   = rd;
        r.data = old;
        r.ill  = ill;
        r.ipc  = ill ? pc : 32'd0;
        r.off  = writes ? 2 : 1;
        rsp_q.push_back(r);

        wait_ready();
        target = rsp_cnt + 1;
        drive_req(f3, addr, idx, data, rd, pc);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        accept_cyc  = cyc;

        n = 0;
        while (rsp_cnt < target && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_cnt < target) begin
            fail_now("rsp_timeout");
            wr_q.delete();
            rsp_q.delete();
        end
    endtask

    logic [11:0] alist [7] = '{12'h340, 12'h300, 12'h304, 12'hC00, 12'hF14, 12'h305, 12'hB00};

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        fill = 1'b0;
        check("reset_ready", req_ready_o, 1'b1);
        check("reset_busy", busy_o, 1'b0);
        check("reset_we", csr_we_o, 1'b0);
        check("reset_rsp_valid", rsp_valid_o, 1'b0);
        check("reset_illegal", illegal_o, 1'b0);
        check("reset_raddr", csr_raddr_o, 12'h0);
        check("reset_rsp_data", rsp_data_o, 32'h0);
        check("reset_illegal_pc", illegal_pc_o, 32'h0);

        // CSRRW
        set_csr(12'h340, 32'h12345678);
        do_op(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 32'h200);
        check("rw_mem", csr_mem[12'h340], 32'hDEADBEEF);

        // CSRRS then CSRRC
        set_csr(12'h300, 32'h00000008);
        do_op(3'b010, 12'h300, 5'd3, 32'h00000088, 5'd1, 32'h204);
        check("rs_mem", csr_mem[12'h300], 32'h00000088);
        do_op(3'b011, 12'h300, 5'd4, 32'h00000008, 5'd2, 32'h208);
        check("rc_mem", csr_mem[12'h300], 32'h00000080);

        // CSRRS with rs1=x0: read only
        set_csr(12'h300, 32'h00001800);
        do_op(3'b010, 12'h300, 5'd0, 32'hFFFFFFFF, 5'd7, 32'h20C);
        check("rs_x0_mem", csr_mem[12'h300], 32'h00001800);

        // Illegal: write to read-only space, reserved funct3
        saved = csr_mem[12'hF14];
        do_op(3'b001, 12'hF14, 5'd2, 32'h0000AAAA, 5'd3, 32'h100);
        check("ro_mem", csr_mem[12'hF14], saved);
        do_op(3'b100, 12'h340, 5'd2, 32'h1, 5'd3, 32'h104);

        // Immediate form
        set_csr(12'h304, 32'h0);
        do_op(3'b110, 12'h304, 5'h1F, 32'hFFFFFFFF, 5'd4, 32'h110);
        check("rsi_mem", csr_mem[12'h304], 32'h0000001F);

        // Flush in the RD cycle
        set_csr(12'h340, 32'h0BADF00D);
        wait_ready();
        drive_req(3'b001, 12'h340, 5'd1, 32'h11111111, 5'd6, 32'h120);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_ready_after", req_ready_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("flush_no_write", csr_mem[12'h340], 32'h0BADF00D);
        do_op(3'b001, 12'h340, 5'd1, 32'h22222222, 5'd6, 32'h124);
        check("post_flush_mem", csr_mem[12'h340], 32'h22222222);

        // Flush in IDLE blocks acceptance
        drive_req(3'b001, 12'h340, 5'd1, 32'h33333333, 5'd6, 32'h128);
        flush_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        check("idle_flush_not_accepted", busy_o, 1'b0);

        // Reset in the WR cycle
        set_csr(12'h305, 32'h55AA55AA);
        wait_ready();
        drive_req(3'b001, 12'h305, 5'd1, 32'hCAFEF00D, 5'd8, 32'h130);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_wr_we", csr_we_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_wr_ready", req_ready_o, 1'b1);
        check("rst_in_wr_mem", csr_mem[12'h305], 32'h55AA55AA);

        // Randomised operations
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [11:0] a;
            logic [4:0]  idx, rd;
            f3  = 3'($urandom_range(0, 7));
            a   = alist[$urandom_range(0, 6)];
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            do_op(f3, a, idx, $urandom, rd, $urandom & 32'hFFFF_FFFC);
        end

        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- Initiator side of the CSR register-file access interface.
- Takes one CSR instruction (CSRRW/RS/RC and their immediate forms) from the execute stage and performs it as a sequenced read-modify-write against the CSR file:
  - drives the CSR file's read address and samples its combinational read data;
  - computes the new value and issues a single write pulse;
  - returns the old value for the rd writeback.
- Flags illegal accesses and supports pipeline flush on trap.

Parameters:
- DATA_W, 32, CSR and GPR data width.
- RO_CHECK_EN, 1, when 1, any write attempt to addr[11:10]==2'b11 is illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  CSR instruction request.
- req_ready_o  out  1  high only in IDLE.
- req_funct3_i  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- req_addr_i  in  12  CSR address.
- req_rs1_idx_i  in  5  rs1 index, or zimm for the immediate forms.
- req_rs1_data_i  in  DATA_W  rs1 value.
- req_rd_i  in  5  destination register.
- req_pc_i  in  32  instruction PC.
- flush_i  in  1  abort the in-flight operation.
- csr_raddr_o  out  12  CSR file read address.
- csr_rdata_i  in  DATA_W  CSR file read data, combinational on csr_raddr_o.
- csr_we_o  out  1  CSR file write enable, one-cycle pulse.
- csr_waddr_o  out  12  write address.
- csr_wdata_o  out  DATA_W  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_we_o  out  1  write rd (rd!=0 and not illegal).
- rsp_rd_o  out  5  destination register.
- rsp_data_o  out  DATA_W  old CSR value.
- illegal_o  out  1  illegal-instruction pulse, coincident with rsp_valid_o.
- illegal_pc_o  out  32  PC of the faulting instruction.
- busy_o  out  1  high whenever state != IDLE (pipeline stall).

Behaviour:
- Reset (sync, rst=1): state=IDLE; all outputs 0 except req_ready_o=1; internal latches cleared.
- States: IDLE, RD, WR, RSP.
- IDLE: req_valid_i && req_ready_o accepts the request. The block latches funct3, addr, rd, pc and the operand:
  - operand = rs1_data for funct3[2]=0;
  - operand = zero-extended rs1_idx (zimm) for funct3[2]=1.
  - Next state: RD.
- RD (one cycle):
  - csr_raddr_o = latched addr;
  - old value = csr_rdata_i, sampled at the clock edge;
  - write intent: RW/RWI always; RS/RC/RSI/RCI only when rs1_idx != 0.
  - illegal = funct3 in {000,100}, or (RO_CHECK_EN && write intent && addr[11:10]==2'b11).
  - Next state: WR if write intent and not illegal, else RSP.
- csr_raddr_o = 0 outside RD.
- WR (one cycle):
  - csr_we_o=1, csr_waddr_o=addr;
  - csr_wdata_o = operand (RW), old|operand (RS), old&~operand (RC).
  - Next state: RSP.
- csr_we_o, csr_waddr_o and csr_wdata_o are 0 outside WR.
- RSP (one cycle):
  - rsp_valid_o=1; rsp_rd_o=rd; rsp_data_o=old;
  - rsp_we_o = (rd!=0) && !illegal;
  - illegal_o = illegal; illegal_pc_o = pc when illegal, else 0.
  - Next state: IDLE.
- Latency: accept at edge N → RD in cycle N+1 → WR in N+2 → RSP in N+3. Without a write, RSP is in N+2.
- Throughput: one operation at a time. req_ready_o=0 in RD/WR/RSP, and requests are ignored there.
- Back-to-back operation: a new request is accepted the cycle after RSP (IDLE).
- flush_i, in any non-IDLE state:
  - next state is IDLE;
  - in the flush cycle, csr_we_o, rsp_valid_o and illegal_o are forced 0, so no CSR side effect occurs unless the write was already issued in an earlier cycle.
  - flush_i in IDLE has no effect; a request in the same cycle as flush_i is not accepted.
- rst during any state: returns to IDLE at the next edge, and no write is issued in that cycle.
- Arithmetic is bitwise only; the zimm operand is 5 bits, upper bits 0.

Test Plan:
- CSRRW addr 0x340, rs1_data 0xDEADBEEF, CSR holds 0x12345678, rd=5:
  - csr_we_o pulse at N+2 with waddr 0x340, wdata 0xDEADBEEF;
  - rsp at N+3 with rsp_data_o=0x12345678, rsp_we_o=1, rsp_rd_o=5.
- CSRRS 0x300, rs1_idx=3, rs1_data 0x00000088, old 0x00000008 → wdata 0x00000088. Then CSRRC with rs1_data 0x8 on old 0x88 → wdata 0x00000080.
- CSRRS 0x300, rs1_idx=0, rd=7, old 0x1800:
  - no csr_we_o;
  - rsp at N+2 with data 0x1800, rsp_we_o=1.
- CSRRW to 0xF14 (read-only), pc 0x100 → no write, illegal_o=1, illegal_pc_o=0x100, rsp_we_o=0. Same with funct3=100 → illegal.
- Immediate form: CSRRSI 0x304, zimm 0x1F, old 0x0 → wdata 0x0000001F.
- Flush cases:
  - flush_i asserted in the RD cycle → no csr_we_o, no rsp_valid_o; req_ready_o=1 next cycle.
  - a follow-up CSRRW completes normally.
  - rst asserted in the WR cycle → csr_we_o=0 that cycle.
